vit_sym_sched: RTL and testbench

- Input scheduler for the (2,1,3) efficient backward-label Viterbi decoder.
- Buffers received code symbols from an upstream valid/ready source and presents them to the decoder's Rx/seq_ready inputs at the cadence the decoder needs:
  - FILL cadence (3 cycles/symbol) until the first traceback window is full.
  - STEADY cadence (15 cycles/symbol) thereafter, one traceback per symbol.
- Replaces hand-timed symbol feeding and tracks decoder output and sync status.

---
 rtl/vit_sched_pkg.sv | 15 +
 rtl/vit_sym_fifo.sv | 41 ++++
 rtl/vit_sym_sched.sv | 114 +++++++++++
 tb/tb_vit_sym_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vit_sched_pkg.sv
// vit_sched_pkg: phase encodings and default parameters shared by the Viterbi symbol scheduler files
package vit_sched_pkg;
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_FILL   = 2'd1,
    PH_STEADY = 2'd2,
    PH_HOLD   = 2'd3
  } phase_e;
  localparam int DEF_N          = 2;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_TB_LEN     = 12;
  localparam int DEF_FILL_CYC   = 3;
  localparam int DEF_STEADY_CYC = 15;
  localparam int DEF_CW         = 16;
endpackage

// File: rtl/vit_sym_fifo.sv
// vit_sym_fifo: symbol FIFO (push/pop/flush in, din/dout data, full/empty status); flush beats push and pop
module vit_sym_fifo
  import vit_sched_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [N-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    full    = wr_q[AW-1:0] == rd_q[AW-1:0] && wr_q[AW] != rd_q[AW];
    empty   = wr_q == rd_q;
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
    wr_d    = flush ? '0 : wr_q + {{AW{1'b0}}, do_push};
    rd_d    = flush ? '0 : rd_q + {{AW{1'b0}}, do_pop};
    dout    = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clock)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/vit_sym_sched.sv
// vit_sym_sched: feeds buffered symbols (in_sym/in_valid/in_ready) to decoder dec_rx/dec_seq_ready at FILL then STEADY cadence; reports phase/busy/sym_cnt/bit_cnt/err; VIT_SCHED_SYNC_FLUSH_EN makes dec_sync_error act as flush
module vit_sym_sched
  import vit_sched_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int TB_LEN     = DEF_TB_LEN,
  parameter int FILL_CYC   = DEF_FILL_CYC,
  parameter int STEADY_CYC = DEF_STEADY_CYC,
  parameter int CW         = DEF_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  in_sym,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [N-1:0]  dec_rx,
  output logic          dec_seq_ready,
  input  logic          dec_oe,
  input  logic          dec_sync_error,
  output logic [1:0]    phase,
  output logic          busy,
  output logic [CW-1:0] sym_cnt,
  output logic [CW-1:0] bit_cnt,
  output logic          err
);
  localparam int CMAX = FILL_CYC > STEADY_CYC ? FILL_CYC : STEADY_CYC;
  localparam int DW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(TB_LEN + 1);
  phase_e ph_q, ph_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] sym_q, sym_d, bit_q, bit_d;
  logic [N-1:0] rx_q, rx_d, head;
  logic err_q, err_d, sr_q, sr_d;
  logic kill, full, empty, load, in_fill;
`ifdef VIT_SCHED_SYNC_FLUSH_EN
  assign kill = flush || dec_sync_error;
`else
  assign kill = flush;
`endif
  assign in_ready      = !full && !flush;
  assign dec_rx        = rx_q;
  assign dec_seq_ready = sr_q;
  assign phase         = ph_q;
  assign busy          = ph_q != PH_IDLE || !empty;
  assign sym_cnt       = sym_q;
  assign bit_cnt       = bit_q;
  assign err           = err_q;
  vit_sym_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (in_valid && in_ready),
    .pop  (load),
    .flush(kill),
    .din  (in_sym),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  // dwell rests at zero in IDLE and HOLD, so a zero dwell means "ready for the next symbol" in every phase
  always_comb begin
    in_fill = fill_q < FW'(TB_LEN);
    load    = !kill && !empty && dwell_q == '0;
    ph_d    = ph_q;
    dwell_d = dwell_q;
    fill_d  = fill_q;
    sym_d   = sym_q;
    rx_d    = rx_q;
    sr_d    = sr_q;
    bit_d   = bit_q + CW'(dec_oe);
    err_d   = err_q || dec_sync_error;
    if (kill) begin
      ph_d    = PH_IDLE;
      sr_d    = 1'b0;
      fill_d  = '0;
      sym_d   = '0;
      dwell_d = '0;
    end else if (load) begin
      rx_d    = head;
      sr_d    = 1'b1;
      dwell_d = in_fill ? DW'(FILL_CYC - 1) : DW'(STEADY_CYC - 1);
      fill_d  = in_fill ? fill_q + 1'b1 : fill_q;
      sym_d   = sym_q + 1'b1;
      ph_d    = in_fill ? PH_FILL : PH_STEADY;
    end else if (dwell_q != '0) begin
      dwell_d = dwell_q - 1'b1;
    end else if (ph_q == PH_FILL || ph_q == PH_STEADY) begin
      ph_d = PH_HOLD;
      sr_d = 1'b0;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ph_q    <= PH_IDLE;
      dwell_q <= '0;
      fill_q  <= '0;
      sym_q   <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      sr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      dwell_q <= dwell_d;
      fill_q  <= fill_d;
      sym_q   <= sym_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      sr_q    <= sr_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_vit_sym_sched.sv
// tb_vit_sym_sched: table vectors plus symbol scoreboard for the Viterbi symbol scheduler
module tb_vit_sym_sched;
  logic clock = 0, reset = 1;
  logic [1:0] in_sym = '0;
  logic in_valid = 0, flush = 0, dec_oe = 0, dec_sync_error = 0;
  logic in_ready, dec_seq_ready, busy, err;
  logic [1:0] dec_rx, phase;
  logic [15:0] sym_cnt, bit_cnt;
  vit_sym_sched dut (
    .clock(clock), .reset(reset), .in_sym(in_sym), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .dec_rx(dec_rx), .dec_seq_ready(dec_seq_ready), .dec_oe(dec_oe),
    .dec_sync_error(dec_sync_error), .phase(phase), .busy(busy), .sym_cnt(sym_cnt),
    .bit_cnt(bit_cnt), .err(err)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [1:0] sym;
    int off;
  } vec_t;
  vec_t tbl [23];
  logic [1:0] s23 [23] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10,
                           2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
  int checks = 0, failures = 0, cyc_n = 0, m_fill = 0, full_cycles = 0;
  int last_t = 0, last_cyc = 0, e_cyc = 0;
  bit have_prev = 0;
  logic [15:0] prev_sc = '0;
  logic [1:0] exp_q [$];
  always @(posedge clock) cyc_n++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc_n);
    end
  endtask
  always @(negedge clock) begin
    if (reset) begin
      prev_sc = '0;
      have_prev = 0;
    end else begin
      if (phase == 2'd0 || phase == 2'd3) have_prev = 0;
      if (sym_cnt == prev_sc + 16'd1) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_rx", dec_rx, exp_q.pop_front());
        e_cyc = m_fill < 12 ? 3 : 15;
        chk("sb_phase", phase, m_fill < 12 ? 1 : 2);
        chk("sb_seq_ready", dec_seq_ready, 1);
        if (have_prev) chk("sb_gap", cyc_n - last_t, last_cyc);
        have_prev = 1;
        last_t = cyc_n;
        last_cyc = e_cyc;
        if (m_fill < 12) m_fill++;
      end
      prev_sc = sym_cnt;
    end
  end
  always @(negedge clock) begin
    #1;
    if (in_valid && !in_ready && !flush) full_cycles++;
  end
  task automatic push_one(input logic [1:0] s);
    int t = 0;
    @(negedge clock);
    in_valid = 1;
    in_sym = s;
    #1;
    while (!in_ready && t < 300) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (in_ready) exp_q.push_back(s);
    else chk("push_timeout", 0, 1);
    @(posedge clock);
    #1 in_valid = 0;
  endtask
  task automatic wait_sc(input logic [15:0] tgt, input string nm);
    int t = 0;
    while (sym_cnt !== tgt && t < 600) begin
      @(negedge clock);
      t++;
    end
    if (sym_cnt !== tgt) chk(nm, sym_cnt, tgt);
  endtask
  task automatic wait_hold(output int n);
    n = 0;
    while (phase !== 2'd3 && n < 600) begin
      @(negedge clock);
      n++;
    end
  endtask
  task automatic wait_drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || phase !== 2'd3) && t < 800) begin
      @(negedge clock);
      t++;
    end
    chk(nm, exp_q.size(), 0);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    exp_q.delete();
    m_fill = 0;
  endtask
  initial begin
    int l0, n, tp;
    logic [1:0] r0;
    logic [15:0] s0;
    for (int i = 0; i < 23; i++) begin
      tbl[i].sym = s23[i];
      tbl[i].off = i < 12 ? 3 * i : 36 + 15 * (i - 12);
    end
    @(negedge clock);
    chk("rst_phase", phase, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_seq_ready", dec_seq_ready, 0);
    chk("rst_sym_cnt", sym_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_rx", dec_rx, 0);
    @(negedge clock);
    reset = 0;
    l0 = 0;
    fork
      for (int i = 0; i < 23; i++) push_one(tbl[i].sym);
      for (int i = 0; i < 23; i++) begin
        wait_sc(16'(i + 1), "t1_load_timeout");
        if (i == 0) l0 = cyc_n;
        chk("t1_rx", dec_rx, tbl[i].sym);
        chk("t1_time", cyc_n - l0, tbl[i].off);
      end
    join
    while (cyc_n < l0 + 200) @(negedge clock);
    chk("t1_last_dwell_phase", phase, 2);
    chk("t1_last_dwell_sr", dec_seq_ready, 1);
    @(negedge clock);
    chk("t1_hold_phase", phase, 3);
    chk("t1_hold_sr", dec_seq_ready, 0);
    chk("t1_sym_cnt", sym_cnt, 23);
    chk("t1_hold_rx", dec_rx, 2'b00);
    do_reset();
    for (int i = 0; i < 12; i++) push_one(2'(i));
    wait_sc(12, "t2_sc12_timeout");
    wait_hold(n);
    chk("t2_fill_dwell", n, 3);
    repeat (50) @(negedge clock);
    chk("t2_still_hold", phase, 3);
    push_one(2'b01);
    tp = cyc_n;
    wait_sc(13, "t2_sc13_timeout");
    chk("t2_load_latency", cyc_n - tp, 1);
    chk("t2_steady_phase", phase, 2);
    wait_hold(n);
    chk("t2_steady_dwell", n, 15);
    chk("t2_rx_held", dec_rx, 2'b01);
    full_cycles = 0;
    for (int i = 0; i < 20; i++) push_one(2'($urandom_range(0, 3)));
    chk("t3_saw_full", full_cycles > 0, 1);
    wait_drain("t3_drain");
    chk("t3_sym_cnt", sym_cnt, 33);
    for (int i = 0; i < 6; i++) push_one(2'(3 - (i % 4)));
    chk("t4_busy", busy, 1);
    chk("t4_phase", phase, 2);
    r0 = dec_rx;
    @(negedge clock);
    flush = 1;
    #1 chk("t4_flush_in_ready", in_ready, 0);
    @(posedge clock);
    #1 flush = 0;
    exp_q.delete();
    m_fill = 0;
    @(negedge clock);
    chk("t4_phase_idle", phase, 0);
    chk("t4_sym_cnt", sym_cnt, 0);
    chk("t4_seq_ready", dec_seq_ready, 0);
    chk("t4_busy_empty", busy, 0);
    chk("t4_rx_kept", dec_rx, r0);
    push_one(2'b10);
    wait_sc(1, "t4_reload_timeout");
    chk("t4_refill_phase", phase, 1);
    wait_hold(n);
    chk("t4_refill_dwell", n, 3);
    for (int i = 0; i < 14; i++) push_one(2'(i + 1));
    wait_sc(13, "t5_sc13_timeout");
    chk("t5_steady", phase, 2);
    dec_sync_error = 1;
    @(posedge clock);
    #1 dec_sync_error = 0;
`ifdef VIT_SCHED_SYNC_FLUSH_EN
    exp_q.delete();
    m_fill = 0;
`endif
    @(negedge clock);
    chk("t5_err", err, 1);
`ifdef VIT_SCHED_SYNC_FLUSH_EN
    chk("t5_phase_idle", phase, 0);
    chk("t5_sym_cnt", sym_cnt, 0);
    chk("t5_busy", busy, 0);
`else
    chk("t5_phase_kept", phase, 2);
    chk("t5_sym_cnt", sym_cnt, 13);
    wait_drain("t5_drain");
    chk("t5_sym_cnt_end", sym_cnt, 15);
`endif
    @(negedge clock);
    dec_oe = 1;
    repeat (7) @(negedge clock);
    dec_oe = 0;
    chk("t6_bit_cnt", bit_cnt, 7);
    chk("t6_err_sticky", err, 1);
    s0 = sym_cnt;
    push_one(2'b11);
    push_one(2'b01);
    wait_sc(s0 + 16'd1, "t6_load_timeout");
    @(negedge clock);
    #3 reset = 1;
    #1;
    chk("t6_bit_cnt_rst", bit_cnt, 0);
    chk("t6_err_rst", err, 0);
    chk("t6_in_ready_rst", in_ready, 1);
    chk("t6_phase_rst", phase, 0);
    chk("t6_sr_rst", dec_seq_ready, 0);
    chk("t6_sym_rst", sym_cnt, 0);
    chk("t6_rx_rst", dec_rx, 0);
    chk("t6_busy_rst", busy, 0);
    exp_q.delete();
    m_fill = 0;
    @(negedge clock);
    reset = 0;
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
